data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU memory control interface.
- Accepts level read/write requests from the memory controller: ReadEnable, 4-bit per-byte WriteEnable, 32-bit word-aligned data lanes.
- Holds a word-organised RAM and signals busy on MemReady (1 = busy, 0 = ready) for a fixed, parameterised number of cycles.
- Sits directly behind the memory controller; it is the simulation/FPGA data memory the controller stalls on.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words (4 KiB default).
- LATENCY, 2, cycles MemReady is held high per access; legal range 1..15.
- LAT_W, 4, width of the internal latency counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Address  in  32  byte address from the controller; bits [ADDR_WIDTH+1:2] select the word, other bits are ignored.
- DataIn  in  32  write data, already lane-replicated by the controller.
- ReadEnable  in  1  read request, level.
- WriteEnable  in  4  per-byte write request, level; bit 3 = DataIn[31:24].
- DataOut  out  32  read data, registered.
- MemReady  out  1  busy flag, registered; 1 = access in progress, 0 = ready/idle.

Behaviour:
- Reset (async, rst=1): MemReady=0, DataOut=32'h0, state IDLE, counter 0, latched request cleared. RAM contents are not reset.
- States: IDLE, BUSY.
- IDLE:
  - Request = ReadEnable | (WriteEnable != 0), sampled on the rising edge.
  - On request, latch the following: word index = Address[ADDR_WIDTH+1:2], DataIn, WriteEnable, ReadEnable.
  - Then load counter = LATENCY, set MemReady=1, go to BUSY.
  - With no request: MemReady=0, DataOut holds.
- BUSY:
  - Inputs are ignored. The controller keeps its request asserted for one further cycle until its mask sets; this must not start a second access.
  - Counter decrements each edge.
  - On the edge where counter==1 (commit edge):
    - For each byte i with latched WE[i]=1, write RAM[idx][8i+7:8i] = latched DataIn byte.
    - If latched read, DataOut = the post-write RAM word at idx.
    - MemReady=0; go to IDLE.
- Timing: MemReady is high for exactly LATENCY cycles, starting the cycle after the request edge. DataOut is valid in the first cycle MemReady=0 and holds until the next read commit.
- Write-only access: DataOut unchanged.
- Read+write in the same request: bytes are written first; DataOut returns the merged word (write-then-read ordering).
- Back-to-back: a request present in the first IDLE cycle after commit is accepted at that edge. There is no dead cycle beyond that.
- Address wrap: upper address bits are ignored, so an address beyond the depth aliases modulo depth. Address[1:0] is ignored; lane selection is carried entirely by WriteEnable.
- Reset mid-BUSY: the access is aborted, no RAM write is committed, and outputs go to their reset values immediately.
- Optional preload: a simulation-only initialisation from file under a define is permitted. It has no port impact.

Test Plan:
- Word path: rst, then write WE=4'b1111, Address=0x10, DataIn=0xDEADBEEF, then read 0x10. Required: MemReady high exactly 2 cycles per access; DataOut=0xDEADBEEF in the first ready cycle.
- Byte lanes: preload 0x11223344 at 0x20, write WE=4'b0100 with DataIn=0xAAAAAAAA. Required: read returns 0x11AA3344. Then write WE=4'b0011 with 0x0000BEEF; required read = 0x11AABEEF.
- Request held 2 cycles, controller-style (ReadEnable high through the first BUSY cycle). Required: exactly one access, MemReady falls once, no second busy period.
- Latency sweep: LATENCY=1 and LATENCY=7. Required: MemReady high for 1 and 7 cycles respectively.
- Simultaneous read+write: WE=4'b0001, DataIn=0x000000FF, ReadEnable=1 on a word holding 0x12345678. Required: DataOut=0x123456FF.
- Reset mid-BUSY: assert rst on the cycle before commit of a write of 0xCAFEF00D to 0x40 holding 0x0. Required: MemReady=0 and DataOut=0 asynchronously; a subsequent read of 0x40 returns 0x0.
- Wrap: write 0x5A5A5A5A at byte address 4*2**ADDR_WIDTH + 8. Required: reading 0x8 returns 0x5A5A5A5A.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-organised data RAM behind the CPU memory controller. A level request
// seen in IDLE is latched and MemReady is held high (busy) for LATENCY
// cycles. On the last busy edge the latched byte lanes are merged into the
// addressed word. For reads, DataOut is loaded with the merged word.
//
// Handshake: a request (ReadEnable or any WriteEnable bit) is taken on the
// first rising edge where the FSM is IDLE. MemReady rises on that edge and
// falls on the commit edge. While MemReady is high, the request inputs are
// ignored, so a request held one cycle too long cannot start a second access.
// DataOut is valid from the first cycle MemReady is low after a read. It then
// holds until the next read commits.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int LAT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic        ReadEnable,
  input  logic [3:0]  WriteEnable,
  output logic [31:0] DataOut,
  output logic        MemReady
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next_state;
  logic [LAT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_data;
  logic [3:0]            r_we;
  logic                  r_re;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_commit;
  logic [31:0]           w_merged;
  logic                  w_dbg_busy;
  logic                  w_unused_addr;

  // Address bits outside the word index only alias; the lanes come from WriteEnable.
  assign w_unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Debug view of the FSM state, for checkers.
  assign w_dbg_busy = (r_state == ST_BUSY);

  assign w_req = ReadEnable | (|WriteEnable);

  // Merge the latched write lanes over the stored word (write-then-read ordering).
  always_comb begin
    w_merged = r_mem[r_idx];
    for (int i = 0; i < 4; i++) begin
      if (r_we[i]) begin
        w_merged[8*i +: 8] = r_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: accept in IDLE, commit when the counter reaches 1.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == LAT_W'(1)) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, latched request, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_we     <= '0;
      r_re     <= 1'b0;
      MemReady <= 1'b0;
      DataOut  <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_idx    <= Address[ADDR_WIDTH+1:2];
        r_data   <= DataIn;
        r_we     <= WriteEnable;
        r_re     <= ReadEnable;
        r_cnt    <= LAT_W'(LATENCY);
        MemReady <= 1'b1;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - LAT_W'(1);
        if (w_commit) begin
          MemReady <= 1'b0;
          r_we     <= '0;
          r_re     <= 1'b0;
          if (r_re) begin
            DataOut <= w_merged;
          end
        end
      end
    end
  end

  // RAM array is not reset. An aborted access never reaches the commit edge,
  // because reset forces the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (w_commit && (|r_we)) begin
      r_mem[r_idx] <= w_merged;
    end
  end

endmodule
